// File: rtl/fm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fm_pkg
//  Description : Shared definitions for the FM audio decimator: audio/DAC
//                widths, the decimator FSM state type and the 20-bit to
//                16-bit saturation helper used by the DC blocker.
//  Revision    : 1.0 - initial release
// ============================================================================
package fm_pkg;

  localparam int AUDIO_W = 16;
  localparam int DAC_W   = 8;
  // Working width of the DC-blocker sum: wide enough that the sum of four
  // full-scale 16-bit terms can never wrap before saturation.
  localparam int DCB_W   = 20;

  localparam logic signed [DCB_W-1:0] SAT_MAX = 20'sd32767;
  localparam logic signed [DCB_W-1:0] SAT_MIN = -20'sd32768;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_DCB  = 2'd1,
    ST_PUSH = 2'd2
  } fm_state_e;

  // Clamp a DC-blocker result into the signed 16-bit audio range.
  function automatic logic signed [AUDIO_W-1:0] sat_audio(
    input logic signed [DCB_W-1:0] v
  );
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[AUDIO_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head entry is
//                presented on rd_data whenever level != 0. A write into a
//                full FIFO is accepted only when a read happens in the same
//                cycle (read frees the slot first).
//  Ports       : clk, rst      - clock, async active-high reset
//                wr_en/wr_data - write request and data
//                rd_en         - pop the head entry (ignored when empty)
//                rd_data       - head entry, zero when empty
//                full          - all DEPTH entries occupied
//                level         - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4    // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic w_empty;
  logic w_do_rd;
  logic w_do_wr;

  assign w_empty = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign w_do_rd = rd_en & ~w_empty;
  assign w_do_wr = wr_en & (~full | w_do_rd);
  assign level   = level_q;
  // Storage is not reset, so the output is forced to zero while empty.
  assign rd_data = w_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (w_do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_do_wr, w_do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/fm_audio_decim.sv
`default_nettype none
// ============================================================================
//  Module      : fm_audio_decim
//  Description : Decimates a 16-bit FM demodulator stream by 2^DECIM_LOG2
//                with a boxcar average, removes DC with a one-pole blocker
//                and queues the audio in a small FWFT FIFO.
//  Ports       : clk, rst            - clock, async active-high reset
//                enable, in_valid    - a sample is taken when both are high
//                demod_in            - signed demodulator sample
//                out_ready           - consumer pops the FIFO head
//                clr_ovf             - clears the sticky overflow flag
//                audio_out, dac_out  - FIFO head, signed and offset-binary
//                out_valid           - FIFO non-empty
//                fifo_level          - FIFO occupancy
//                overflow            - a decimated sample was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module fm_audio_decim
  import fm_pkg::*;
#(
  parameter int DECIM_LOG2 = 6,
  parameter int DCB_SHIFT  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [AUDIO_W-1:0]     demod_in,
  input  logic                          in_valid,
  input  logic                          out_ready,
  input  logic                          clr_ovf,
  output logic signed [AUDIO_W-1:0]     audio_out,
  output logic [DAC_W-1:0]              dac_out,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int ACC_W = AUDIO_W + DECIM_LOG2;
  localparam int EXT_W = DCB_W - AUDIO_W;

  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DECIM_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [AUDIO_W-1:0] avg_q, avg_d;
  logic signed [AUDIO_W-1:0] x_prev_q, x_prev_d;
  logic signed [AUDIO_W-1:0] y_prev_q, y_prev_d;
  fm_state_e                 state_q, state_d;
  logic                      ovf_q, ovf_d;

  logic                      w_accept;
  logic                      w_dump;
  logic signed [ACC_W-1:0]   w_sample_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [AUDIO_W-1:0] w_leak;
  logic signed [DCB_W-1:0]   w_y_wide;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_wr_en;
  logic                      w_drop;
  logic [AUDIO_W-1:0]        w_fifo_head;

  assign w_accept     = in_valid & enable;
  assign w_sample_ext = {{DECIM_LOG2{demod_in[AUDIO_W-1]}}, demod_in};
  assign w_sum        = acc_q + w_sample_ext;
  assign w_dump       = w_accept && (cnt_q == '1);

  // y = avg - x_prev + y_prev - (y_prev >>> DCB_SHIFT), evaluated at DCB_W bits.
  assign w_leak   = y_prev_q >>> DCB_SHIFT;
  assign w_y_wide = {{EXT_W{avg_q[AUDIO_W-1]}},    avg_q}
                  - {{EXT_W{x_prev_q[AUDIO_W-1]}}, x_prev_q}
                  + {{EXT_W{y_prev_q[AUDIO_W-1]}}, y_prev_q}
                  - {{EXT_W{w_leak[AUDIO_W-1]}},   w_leak};

  // y_prev_q holds the saturated result from DCB, so PUSH writes it directly.
  // A pop in the same cycle frees a slot in a full FIFO before the write.
  assign w_push  = (state_q == ST_PUSH);
  assign w_pop   = out_valid & out_ready;
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // Accumulator and counter run regardless of FSM state.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    avg_d = avg_q;
    if (w_accept) begin
      cnt_d = cnt_q + 1'b1;
      if (w_dump) begin
        acc_d = '0;
        // Upper AUDIO_W bits of the sum equal (sum >>> DECIM_LOG2).
        avg_d = w_sum[ACC_W-1:DECIM_LOG2];
      end else begin
        acc_d = w_sum;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    x_prev_d = x_prev_q;
    y_prev_d = y_prev_q;
    case (state_q)
      ST_ACC:  if (w_dump) state_d = ST_DCB;
      ST_DCB: begin
        x_prev_d = avg_q;
        y_prev_d = sat_audio(w_y_wide);
        state_d  = ST_PUSH;
      end
      ST_PUSH: state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // Set dominates clear when both happen in one cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (w_drop)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      avg_q    <= '0;
      x_prev_q <= '0;
      y_prev_q <= '0;
      state_q  <= ST_ACC;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      avg_q    <= avg_d;
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
      state_q  <= state_d;
      ovf_q    <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (AUDIO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_data (y_prev_q),
    .rd_en   (w_pop),
    .rd_data (w_fifo_head),
    .full    (w_full),
    .level   (fifo_level)
  );

  assign audio_out = w_fifo_head;
  assign out_valid = (fifo_level != '0);
  assign overflow  = ovf_q;
  // Offset binary: top byte of the sample with its sign bit inverted.
  assign dac_out   = {~audio_out[AUDIO_W-1], audio_out[AUDIO_W-2 -: DAC_W-1]};

endmodule
`default_nettype wire

// File: tb/tb_fm_audio_decim.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fm_audio_decim
//  Description : Self-checking bench for fm_audio_decim. A reference model
//                built from averaging/DC-blocker arithmetic feeds an expected
//                queue; a negedge monitor pops and compares on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_audio_decim;

  localparam int DL    = 2;
  localparam int DS    = 8;
  localparam int DEPTH = 4;
  localparam int NSAMP = 1 << DL;

  logic               clk       = 1'b0;
  logic               rst       = 1'b0;
  logic               enable    = 1'b0;
  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b0;
  logic               clr_ovf   = 1'b0;
  logic signed [15:0] demod_in  = '0;
  logic signed [15:0] audio_out;
  logic [7:0]         dac_out;
  logic               out_valid;
  logic [2:0]         fifo_level;
  logic               overflow;

  fm_audio_decim #(
    .DECIM_LOG2 (DL),
    .DCB_SHIFT  (DS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .demod_in   (demod_in),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .clr_ovf    (clr_ovf),
    .audio_out  (audio_out),
    .dac_out    (dac_out),
    .out_valid  (out_valid),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int val;
  } pend_t;

  pend_t pend[$];
  int    exp_q[$];
  int    got_q[$];
  int    m_samples[$];
  int    m_xp, m_yp, m_level, cyc;
  bit    m_ovf;

  function automatic int floor_div(input int a, input int d);
    int r;
    r = a % d;
    if (r < 0) r += d;
    return (a - r) / d;
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    pend_t p;
    int    sum, avg, y;
    bit    pop, drop;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      m_samples.delete();
      m_xp = 0; m_yp = 0; m_level = 0; cyc = 0; m_ovf = 1'b0;
    end else begin
      cyc++;
      pop  = (m_level > 0) && out_ready;
      drop = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        if (m_level < DEPTH || pop) begin
          exp_q.push_back(p.val);
          m_level++;
        end else begin
          drop = 1'b1;
        end
      end
      if (pop) m_level--;
      if (clr_ovf) m_ovf = 1'b0;
      if (drop)    m_ovf = 1'b1;
      if (in_valid && enable) begin
        m_samples.push_back(int'(demod_in));
        if (m_samples.size() == NSAMP) begin
          sum = 0;
          foreach (m_samples[k]) sum += m_samples[k];
          avg  = floor_div(sum, NSAMP);
          y    = clamp16(avg - m_xp + m_yp - floor_div(m_yp, 1 << DS));
          m_xp = avg;
          m_yp = y;
          p.due = cyc + 2;   // average taken now, written two edges later
          p.val = y;
          pend.push_back(p);
          m_samples.delete();
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int e;
    if (mon_en) begin
      chk("out_valid", int'(out_valid), int'(m_level != 0));
      chk("fifo_level", int'(fifo_level), m_level);
      chk("overflow", int'(overflow), int'(m_ovf));
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %0d, required no output", audio_out);
        end else begin
          e = exp_q.pop_front();
          chk("audio_out", int'(audio_out), e);
          chk("dac_out", int'(dac_out), floor_div(e + 32768, 256));
          got_q.push_back(int'(audio_out));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_audio"}, int'(audio_out), 0);
    chk({tag, "_dac"}, int'(dac_out), 128);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_level"}, int'(fifo_level), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    enable = 1'b1;
    got_q.delete();
  endtask

  task automatic feed(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      demod_in = 16'(v);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((pend.size() != 0 || m_level != 0) && k < 60) begin
      tick();
      k++;
    end
    if (k >= 60) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got level %0d, required 0", m_level);
    end
    tick();
    chk("exp_left", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    #1;
    do_reset();
    mon_en = 1'b1;

    // Constant 1000 stream with latency probe
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      demod_in = 16'sd1000;
      in_valid = 1'b1;
      tick();
      if (i == 4) chk("latency_dcb_valid", int'(out_valid), 0);
      if (i == 5) chk("latency_push_valid", int'(out_valid), 1);
    end
    drain();
    chk("const_cnt", got_q.size(), 3);
    chk("const_0", got_q[0], 1000);
    chk("const_1", got_q[1], 997);
    chk("const_2", got_q[2], 994);

    // Overflow with stalled consumer, then clear
    do_reset();
    feed(1000, 20);
    repeat (4) tick();
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_flag", int'(overflow), 1);
    drain();
    chk("ovf_cnt", got_q.size(), 4);
    chk("ovf_0", got_q[0], 1000);
    chk("ovf_1", got_q[1], 997);
    chk("ovf_2", got_q[2], 994);
    chk("ovf_3", got_q[3], 991);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Saturation at both rails
    do_reset();
    out_ready = 1'b1;
    feed(32767, 4);
    feed(-32768, 4);
    drain();
    chk("sat_cnt", got_q.size(), 2);
    chk("sat_pos", got_q[0], 32767);
    chk("sat_neg", got_q[1], -32768);

    // Gapped valid with enable dropped mid-stream
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      demod_in = 16'(200 * (i + 1));
      in_valid = (i % 2) == 0;
      enable   = !(i >= 8 && i <= 10);
      tick();
    end
    enable = 1'b1;
    drain();
    chk("gap_cnt", got_q.size(), 2);
    chk("gap_0", got_q[0], 800);
    chk("gap_1", got_q[1], 3197);

    // Reset in the middle of an accumulation
    do_reset();
    out_ready = 1'b1;
    feed(777, 2);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    got_q.delete();
    feed(400, 4);
    drain();
    chk("midrst_cnt", got_q.size(), 1);
    chk("midrst_val", got_q[0], 400);

    // Full FIFO, consumer ready exactly in the PUSH cycle
    do_reset();
    feed(1000, 16);
    repeat (4) tick();
    chk("full_pre_level", int'(fifo_level), 4);
    feed(1000, 4);        // dump edge just passed
    tick();               // DCB edge
    out_ready = 1'b1;
    tick();               // PUSH edge with simultaneous pop
    out_ready = 1'b0;
    chk("full_push_level", int'(fifo_level), 4);
    chk("full_push_ovf", int'(overflow), 0);
    drain();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      demod_in  = 16'($urandom);
      in_valid  = ($urandom % 4) != 0;
      enable    = ($urandom % 8) != 0;
      out_ready = (i < 300) ? (($urandom % 6) == 0) : (($urandom % 3) != 0);
      clr_ovf   = ($urandom % 50) == 0;
      tick();
    end
    clr_ovf = 1'b0;
    enable  = 1'b1;
    drain();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fm_audio_decim.md
FM_AUDIO_DECIM -- requirements
Module: fm_audio_decim

Interface
REQ-001 Parameters SHALL be: DECIM_LOG2, default 6, log2 of the decimation ratio (legal range 2..8); DCB_SHIFT, default 8, DC-blocker pole shift, alpha = 1 - 2^-DCB_SHIFT; FIFO_DEPTH, default 4, output FIFO entries (power of two).
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-high.
REQ-004 enable  in  1  sample acceptance enable.
REQ-005 demod_in  in  16  signed demodulator output sample.
REQ-006 in_valid  in  1  demod_in is valid this cycle.
REQ-007 out_ready  in  1  consumer accepts the head audio sample.
REQ-008 clr_ovf  in  1  clears the overflow flag.
REQ-009 audio_out  out  16  signed decimated, DC-blocked audio; the FIFO head.
REQ-010 dac_out  out  8  offset-binary DAC code: audio_out[15:8] with the MSB inverted.
REQ-011 out_valid  out  1  audio_out and dac_out are valid.
REQ-012 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of entries currently stored.
REQ-013 overflow  out  1  sticky flag; a decimated sample was dropped.

Function
REQ-014 A sample SHALL be accepted when in_valid&&enable; otherwise the accumulator and counter hold their values.
REQ-015 Each accepted sample SHALL be sign-extended into a (16+DECIM_LOG2)-bit accumulator, and a DECIM_LOG2-bit counter SHALL increment.
REQ-016 The accepted sample with counter==2^DECIM_LOG2-1 SHALL produce the dump: avg = (acc + sample) >>> DECIM_LOG2 (arithmetic shift); the accumulator clears to 0 and the counter wraps to 0 in the same cycle.
REQ-017 The FSM SHALL have three states: ACC (idle/accumulating), DCB, and PUSH. ACC->DCB on dump; DCB->PUSH unconditionally; PUSH->ACC unconditionally.
REQ-018 The accumulator SHALL run independently of the FSM, so samples arriving during DCB or PUSH are accumulated normally.
REQ-019 In DCB: y = avg - x_prev + y_prev - (y_prev >>> DCB_SHIFT), computed at 20 bits and saturated to [-32768, 32767]; x_prev <= avg; y_prev <= the saturated y.
REQ-020 In PUSH: the saturated y SHALL be written to the FIFO if it is not full; if it is full, y is dropped and overflow <= 1.
REQ-021 When the FIFO is full and out_ready is high, the pop SHALL occur first, so the PUSH write is accepted and no overflow is raised.
REQ-022 The FIFO SHALL be first-word-fall-through; out_valid = (fifo_level != 0); a pop occurs when out_valid&&out_ready.
REQ-023 Latency: dump in cycle N, DCB in N+1, FIFO write in N+2; out_valid rises in N+3 when the FIFO was empty.
REQ-024 Simultaneous write and pop SHALL leave fifo_level unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 clr_ovf clears overflow; if clr_ovf and a drop occur in the same cycle, the set wins.
REQ-026 Deasserting enable SHALL NOT abort an in-flight DCB or PUSH.

Reset
REQ-027 While rst=1, the following SHALL be zero: acc, counter, x_prev, y_prev, FIFO pointers, fifo_level, overflow, out_valid, and audio_out. dac_out SHALL be 0x80. The FSM SHALL be in ACC.
REQ-028 Reset asserted mid-operation SHALL discard the partial accumulation, the in-flight sample, and all FIFO contents.

Structure
REQ-029 A shared package fm_pkg SHALL hold: the FSM state enum (ACC/DCB/PUSH), AUDIO_W=16, DAC_W=8, and the saturation function.
REQ-030 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth; the accumulator, DC blocker, and FSM live in fm_audio_decim.

Verification
All scenarios use DECIM_LOG2=2, DCB_SHIFT=8, FIFO_DEPTH=4 unless stated otherwise.
REQ-031 Constant 1000, in_valid=1, out_ready=1 -> audio_out 1000, then 997, then 994; the first out_valid occurs 3 cycles after the 4th sample.
REQ-032 out_ready=0 for 5 dumps of constant 1000 -> fifo_level=4 and overflow=1 after the 5th PUSH; the popped sequence is 1000, 997, 994, 991; clr_ovf=1 clears overflow.
REQ-033 4 samples of 32767, then 4 of -32768 -> audio_out 32767 (dac_out 0xFF), then -32768 saturated (dac_out 0x00).
REQ-034 in_valid toggling every other cycle with enable=0 for the middle 3 cycles -> a dump occurs only after 4 accepted samples; the averages are unchanged.
REQ-035 rst pulse after 2 of 4 samples -> all outputs at reset values; the next 4 samples of 400 yield audio_out 400.
REQ-036 FIFO full with out_ready=1 in the PUSH cycle -> the write is accepted, fifo_level stays 4, and overflow stays 0.
